axis_gearbox_256to192: RTL
==========================

AXIS_GEARBOX_256TO192 -- requirements
Module: axis_gearbox_256to192

Interface
REQ-001 Parameters SHALL be none; data widths are fixed at 256 in and 192 out.
REQ-002 axis_aclk_in  input  1  sole clock, all logic rising-edge.
REQ-003 axis_rstb_in  input  1  reset, asynchronous, active-low.
REQ-004 axis_tvalid_in  input  1  upstream beat valid.
REQ-005 axis_tready_in  output  1  upstream beat accepted when tvalid_in && tready_in.
REQ-006 axis_tdata_in  input  256  upstream data.
REQ-007 axis_tvalid_out  output  1  downstream beat valid, registered.
REQ-008 axis_tready_out  input  1  downstream ready.
REQ-009 axis_tdata_out  output  192  downstream data, registered.

Function
REQ-010 Packing SHALL be LSB-first: 3 input beats i0,i1,i2 form {i2,i1,i0}, emitted as 4 output beats o0..o3 of 192 bits, o0 from the LSBs.
REQ-011 The FSM SHALL have states P0 (no residue), P1 (64-bit residue), P2 (128-bit residue) and P3 (192-bit residue, drain).
REQ-012 The mapping SHALL be:
- P0 accept: out=in[191:0], res={128'b0,in[255:192]}, ->P1.
- P1 accept: out={in[127:0],res[63:0]}, res={64'b0,in[255:128]}, ->P2.
- P2 accept: out={in[63:0],res[127:0]}, res=in[255:64], ->P3.
- P3: out=res with no input consumed, ->P0.
REQ-013 load_ok SHALL equal !axis_tvalid_out || axis_tready_out.
REQ-014 axis_tready_in SHALL equal load_ok && (state != P3), combinationally.
REQ-015 Output register update: on load_ok, load the new beat with tvalid_out=1 when accepting in P0-P2 or draining in P3; otherwise, if tready_out, tvalid_out SHALL go to 0.
REQ-016 Latency SHALL be 1 cycle from input accept to tvalid_out.
REQ-017 Throughput SHALL be 4 output beats per 3 input beats, back-to-back with no bubbles when tvalid_in=1 and tready_out=1.
REQ-018 While tvalid_out=1 and tready_out=0, tdata_out SHALL stay stable and neither state nor residue SHALL change.
REQ-019 A P3 drain SHALL occur regardless of tvalid_in.

Reset
REQ-020 While axis_rstb_in=0: state=P0, residue=0, tvalid_out=0, tdata_out=0, and last flags =0.
REQ-021 Reset asserted mid-group SHALL discard the residue, with no partial beat emitted after release.
REQ-022 axis_tready_in SHALL be 1 in the first cycle after reset release.

Configuration
REQ-023 Macro AXIS_GEARBOX_TLAST_EN SHALL add ports axis_tlast_in (input, 1) and axis_tlast_out (output, 1, registered, reset 0).
REQ-024 With AXIS_GEARBOX_TLAST_EN, an accepted beat with tlast_in=1 SHALL:
- in P0 or P1, emit the normal beat with tlast_out=0, then go to P3 with last_pend=1;
- in P2, go to P3 as normal with last_pend=1.
REQ-025 The P3 drain with last_pend=1 SHALL emit the zero-padded residue with tlast_out=1, clear last_pend and go to P0.
REQ-026 Without AXIS_GEARBOX_TLAST_EN, no tlast ports or logic SHALL exist and P3 SHALL be entered only from P2.

Structure
REQ-027 Package axis_gearbox_pkg SHALL hold the IN_W=256, OUT_W=192 and RES_W=192 constants and the phase enum (P0..P3).
REQ-028 The block SHALL be a single module with no sub-module, and no FIFO.

Verification
REQ-029 Reset then 3 beats i0=256'h...0001_..., each word a distinct counter pattern, with tready_out=1 -> exactly 4 outputs matching REQ-012, the 4th with tready_in=0 in that cycle.
REQ-030 Continuous valid for 300 input beats with tready_out=1 -> 400 outputs, zero bubbles, with the data stream bit-identical to the input stream.
REQ-031 tready_out held 0 for 5 cycles mid-P2 -> tdata_out stable, tready_in=0 after the output register fills, and no data loss on release.
REQ-032 Random tvalid_in and tready_out (50%) for 3000 beats -> scoreboard match, with no output while the FSM is idle.
REQ-033 Reset asserted in P2 with residue nonzero -> tvalid_out=0, and the next 3 inputs produce o0..o3 aligned from P0.
REQ-034 AXIS_GEARBOX_TLAST_EN, tlast on the 1st beat -> 2 outputs: in[191:0] with tlast=0, then {128'b0,in[255:192]} with tlast=1; the next frame restarts at P0.

Source files
------------

// File: rtl/axis_gearbox_pkg.sv
// Shared widths and phase encoding for the 256-to-192 AXI-Stream gearbox.
package axis_gearbox_pkg;

    localparam int IN_W  = 256;
    localparam int OUT_W = 192;
    localparam int RES_W = 192;

    // Phase names the residue size: P0 none, P1 64b, P2 128b, P3 192b (drain).
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

endpackage

// File: rtl/axis_gearbox_256to192_if.sv
// Upstream/downstream stream bundle for the gearbox.
// Optional TLAST pair is present only when AXIS_GEARBOX_TLAST_EN is defined.
interface axis_gearbox_256to192_if;
    import axis_gearbox_pkg::*;

    logic             axis_tvalid_in;
    logic             axis_tready_in;
    logic [IN_W-1:0]  axis_tdata_in;
    logic             axis_tvalid_out;
    logic             axis_tready_out;
    logic [OUT_W-1:0] axis_tdata_out;
`ifdef AXIS_GEARBOX_TLAST_EN
    logic             axis_tlast_in;
    logic             axis_tlast_out;
`endif

    modport slave (
        input  axis_tvalid_in,
        input  axis_tdata_in,
        input  axis_tready_out,
`ifdef AXIS_GEARBOX_TLAST_EN
        input  axis_tlast_in,
        output axis_tlast_out,
`endif
        output axis_tready_in,
        output axis_tvalid_out,
        output axis_tdata_out
    );

    modport master (
        output axis_tvalid_in,
        output axis_tdata_in,
        output axis_tready_out,
`ifdef AXIS_GEARBOX_TLAST_EN
        output axis_tlast_in,
        input  axis_tlast_out,
`endif
        input  axis_tready_in,
        input  axis_tvalid_out,
        input  axis_tdata_out
    );

endinterface

// File: rtl/axis_gearbox_256to192.sv
// LSB-first 256->192 gearbox: 3 input beats become 4 output beats via a residue register.
// Define AXIS_GEARBOX_TLAST_EN to add TLAST framing with a zero-padded flush of the residue.
module axis_gearbox_256to192
    import axis_gearbox_pkg::*;
(
    input logic                    axis_aclk_in,
    input logic                    axis_rstb_in,
    axis_gearbox_256to192_if.slave axis_if
);

    phase_e             r_state;
    phase_e             w_state_nxt;
    logic [RES_W-1:0]   r_res;
    logic [RES_W-1:0]   w_res_nxt;
    logic               r_tvalid_out;
    logic               w_tvalid_nxt;
    logic [OUT_W-1:0]   r_tdata_out;
    logic [OUT_W-1:0]   w_tdata_nxt;
`ifdef AXIS_GEARBOX_TLAST_EN
    logic               r_last_pend;
    logic               w_last_pend_nxt;
    logic               r_tlast_out;
    logic               w_tlast_nxt;
`endif

    logic               w_load_ok;
    logic               w_tready_in;
    logic               w_accept;

    // Output register may load whenever it is empty or being drained this cycle.
    assign w_load_ok   = !r_tvalid_out || axis_if.axis_tready_out;
    assign w_tready_in = w_load_ok && (r_state != P3);
    assign w_accept    = axis_if.axis_tvalid_in && w_tready_in;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_res_nxt    = r_res;
        w_tvalid_nxt = r_tvalid_out;
        w_tdata_nxt  = r_tdata_out;
`ifdef AXIS_GEARBOX_TLAST_EN
        w_last_pend_nxt = r_last_pend;
        w_tlast_nxt     = r_tlast_out;
`endif
        if (w_load_ok) begin
            w_tvalid_nxt = 1'b0;
            if (r_state == P3) begin
                w_tdata_nxt  = r_res;
                w_res_nxt    = '0;
                w_tvalid_nxt = 1'b1;
                w_state_nxt  = P0;
`ifdef AXIS_GEARBOX_TLAST_EN
                w_tlast_nxt     = r_last_pend;
                w_last_pend_nxt = 1'b0;
`endif
            end else if (w_accept) begin
                w_tvalid_nxt = 1'b1;
                case (r_state)
                    P0: begin
                        w_tdata_nxt = axis_if.axis_tdata_in[191:0];
                        w_res_nxt   = {128'b0, axis_if.axis_tdata_in[255:192]};
                        w_state_nxt = P1;
                    end
                    P1: begin
                        w_tdata_nxt = {axis_if.axis_tdata_in[127:0], r_res[63:0]};
                        w_res_nxt   = {64'b0, axis_if.axis_tdata_in[255:128]};
                        w_state_nxt = P2;
                    end
                    default: begin
                        w_tdata_nxt = {axis_if.axis_tdata_in[63:0], r_res[127:0]};
                        w_res_nxt   = axis_if.axis_tdata_in[255:64];
                        w_state_nxt = P3;
                    end
                endcase
`ifdef AXIS_GEARBOX_TLAST_EN
                // A frame end forces an early drain of whatever residue is left.
                w_tlast_nxt = 1'b0;
                if (axis_if.axis_tlast_in) begin
                    w_state_nxt     = P3;
                    w_last_pend_nxt = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge axis_aclk_in or negedge axis_rstb_in) begin
        if (!axis_rstb_in) begin
            r_state      <= P0;
            r_res        <= '0;
            r_tvalid_out <= 1'b0;
            r_tdata_out  <= '0;
`ifdef AXIS_GEARBOX_TLAST_EN
            r_last_pend  <= 1'b0;
            r_tlast_out  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the same pre-edge values.
            r_state      <= w_state_nxt;
            r_res        <= w_res_nxt;
            r_tvalid_out <= w_tvalid_nxt;
            r_tdata_out  <= w_tdata_nxt;
`ifdef AXIS_GEARBOX_TLAST_EN
            r_last_pend  <= w_last_pend_nxt;
            r_tlast_out  <= w_tlast_nxt;
`endif
        end
    end

    assign axis_if.axis_tready_in  = w_tready_in;
    assign axis_if.axis_tvalid_out = r_tvalid_out;
    assign axis_if.axis_tdata_out  = r_tdata_out;
`ifdef AXIS_GEARBOX_TLAST_EN
    assign axis_if.axis_tlast_out  = r_tlast_out;
`endif

endmodule
